alu_cmd_issue: RTL and testbench
================================

ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: cmd_valid  input  1  upstream command present.
REQ-005 Port: cmd_ready  output  1  block can accept a command this cycle.
REQ-006 Port: cmd_a / cmd_b  input  4 each  operands.
REQ-007 Port: cmd_op  input  2  ALU opcode: 00 add, 01 sub, 10 or, 11 xor.
REQ-008 Port: alu_a / alu_b  output  4 each  registered operands to the combinational ALU's a/b.
REQ-009 Port: alu_op  output  2  registered opcode to the ALU's op.
REQ-010 Port: alu_out  input  4  combinational ALU result.
REQ-011 Port: res_valid  output  1  result available.
REQ-012 Port: res_ready  input  1  downstream accepts result.
REQ-013 Port: res_data  output  4  captured ALU result.
REQ-014 Port: res_op  output  2  opcode that produced res_data.

Function
REQ-015 Command accepted on a rising edge where cmd_valid && cmd_ready; {cmd_a, cmd_b, cmd_op} written to the FIFO tail.
REQ-016 cmd_ready SHALL be !full, driven from registered occupancy only, with no combinational path from res_ready or cmd_valid.
REQ-017 FIFO read/write pointers wrap modulo DEPTH; simultaneous push and pop leaves occupancy unchanged; no push when full; no pop when empty.
REQ-018 FSM states: IDLE, EXEC, HOLD.
REQ-019 IDLE: if FIFO non-empty, load alu_a/alu_b/alu_op from head, pop, go to EXEC; otherwise stay in IDLE with alu_* held.
REQ-020 EXEC (exactly one cycle): capture res_data <= alu_out and res_op <= alu_op, set res_valid, go to HOLD.
REQ-021 HOLD: res_valid, res_data and res_op are stable until res_ready is high.
REQ-022 HOLD exit on res_ready: if FIFO non-empty, clear res_valid, load the next head into alu_*, pop, and go to EXEC; otherwise clear res_valid and go to IDLE.
REQ-023 Latency: a command accepted at edge k into an empty, idle block updates alu_* at edge k+1 and asserts res_valid after edge k+2.
REQ-024 Steady-state throughput with res_ready held high: one result per 2 cycles.
REQ-025 Results SHALL be returned in acceptance order, with no loss or duplication.
REQ-026 alu_* outputs hold their last value outside load events.

Reset
REQ-027 While rst is high at a rising edge, the block SHALL clear FIFO pointers and occupancy, set state to IDLE, and drive res_valid=0, res_data=0, res_op=0, alu_a=0, alu_b=0, alu_op=0.
REQ-028 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-operation discards all queued and in-flight commands, including a result held in HOLD; no result is emitted for them.
REQ-030 A command presented in a reset cycle is not accepted.

Configuration
REQ-031 Macro ALU_ZERO_FLAG_EN: when defined, adds output port res_zero (1 bit), captured in EXEC as (alu_out == 0), held with res_data, and reset to 0.
REQ-032 Without ALU_ZERO_FLAG_EN, the res_zero port and its register SHALL NOT exist; all other behaviour is identical.

Verification
REQ-033 Push A=10, B=3 with ops 00, 01, 10, 11 back-to-back, res_ready=1 -> res_data 13, 7, 11, 9 in order, with res_op matching.
REQ-034 Single command A=10, B=3, op=00 accepted at edge k into an idle block -> alu_a=10 after edge k+1; res_valid=1 and res_data=13 after edge k+2.
REQ-035 res_ready=0, push 5 commands with DEPTH=4 -> cmd_ready drops after the FIFO fills; a held result stays stable; releasing res_ready drains all results in order.
REQ-036 Wrap-around: A=3, B=10, op=01 -> res_data=9; A=15, B=1, op=00 -> res_data=0 (with ALU_ZERO_FLAG_EN, res_zero=1).
REQ-037 Assert rst while in HOLD with 2 commands queued -> next cycle res_valid=0, cmd_ready=1, alu_*=0, and no stale results appear afterwards.

Source files
------------

// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issue
// Purpose  : Queues ALU commands in a small FIFO and issues them one at a
//            time to an external combinational ALU. Each result is captured
//            and held under a valid/ready handshake until it is accepted.
// Options  : ALU_ZERO_FLAG_EN - adds the res_zero output (result == 0).
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_issue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [1:0] res_op
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic       res_zero
`endif
);

    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL    = (c_AW + 1)'(DEPTH);
    localparam logic [1:0]    c_ST_IDLE = 2'd0;
    localparam logic [1:0]    c_ST_EXEC = 2'd1;
    localparam logic [1:0]    c_ST_HOLD = 2'd2;

    logic [3:0]      r_mem_a  [DEPTH];
    logic [3:0]      r_mem_b  [DEPTH];
    logic [1:0]      r_mem_op [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;
    logic [3:0]      r_alu_a;
    logic [3:0]      r_alu_b;
    logic [1:0]      r_alu_op;
    logic            r_res_valid;
    logic [3:0]      r_res_data;
    logic [1:0]      r_res_op;

    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    // cmd_ready is a pure function of the occupancy register
    assign w_empty   = (r_count == '0);
    assign cmd_ready = (r_count != c_FULL);
    assign w_push    = cmd_valid && cmd_ready;

    // The head is consumed whenever the sequencer loads a new command
    assign w_pop = !w_empty &&
                   ((r_state == c_ST_IDLE) ||
                    ((r_state == c_ST_HOLD) && res_ready));

    // FIFO storage; entries are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_a[r_wptr]  <= cmd_a;
            r_mem_b[r_wptr]  <= cmd_b;
            r_mem_op[r_wptr] <= cmd_op;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_AW + 1)'(1);
            end
        end
    end

    // Issue sequencer: load operands, capture the ALU result, hold it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_op    <= 2'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 4'd0;
            r_res_op    <= 2'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_alu_a  <= r_mem_a[r_rptr];
                        r_alu_b  <= r_mem_b[r_rptr];
                        r_alu_op <= r_mem_op[r_rptr];
                        r_state  <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_res_data  <= alu_out;
                    r_res_op    <= r_alu_op;
                    r_res_valid <= 1'b1;
                    r_state     <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (!w_empty) begin
                            r_alu_a  <= r_mem_a[r_rptr];
                            r_alu_b  <= r_mem_b[r_rptr];
                            r_alu_op <= r_mem_op[r_rptr];
                            r_state  <= c_ST_EXEC;
                        end else begin
                            r_state  <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic r_res_zero;

    // Zero flag is captured alongside res_data and held with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_zero <= 1'b0;
        end else if (r_state == c_ST_EXEC) begin
            r_res_zero <= (alu_out == 4'd0);
        end
    end

    assign res_zero = r_res_zero;
`endif

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_issue
// Purpose  : Self-checking bench for alu_cmd_issue: directed scenarios plus
//            randomized traffic against an ordered reference queue.
// Options  : ALU_ZERO_FLAG_EN - also checks res_zero.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issue;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] op;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [1:0] res_op;
`ifdef ALU_ZERO_FLAG_EN
    logic       res_zero;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    exp_t       q_exp[$];
    logic [3:0] log_data[$];
    int         hs_cyc[$];
    logic       prev_hold = 1'b0;
    logic [3:0] prev_data = 4'd0;
    logic [1:0] prev_op   = 2'd0;
    logic [3:0] c_seq4 [4];

    alu_cmd_issue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .res_zero  (res_zero)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External combinational ALU seen by the block
    always_comb begin
        alu_out = 4'd0;
        case (alu_op)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            2'b10:   alu_out = alu_a | alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    // Reference result from the opcode table, in plain integer arithmetic
    function automatic logic [3:0] f_ref(input int a, input int b, input int op);
        int s;
        case (op)
            0:       s = a + b;
            1:       s = a - b + 16;
            2:       s = a | b;
            default: s = a ^ b;
        endcase
        return 4'(s % 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs settle well before negedge, so the values here are
    // the ones the next rising edge will act on
    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_data",  32'(res_data),  32'(prev_data));
                check("hold_op",    32'(res_op),    32'(prev_op));
            end
            if (res_valid && res_ready) begin
                check("result_expected", 32'(q_exp.size() != 0), 32'd1);
                if (q_exp.size() != 0) begin
                    check("res_data", 32'(res_data), 32'(q_exp[0].d));
                    check("res_op",   32'(res_op),   32'(q_exp[0].op));
`ifdef ALU_ZERO_FLAG_EN
                    check("res_zero", 32'(res_zero), 32'(q_exp[0].d == 4'd0));
`endif
                    void'(q_exp.pop_front());
                end
                log_data.push_back(res_data);
                hs_cyc.push_back(cyc);
            end
            if (cmd_valid && cmd_ready) begin
                q_exp.push_back('{d: f_ref(int'(cmd_a), int'(cmd_b), int'(cmd_op)), op: cmd_op});
            end
            prev_hold <= res_valid && !res_ready;
            prev_data <= res_data;
            prev_op   <= res_op;
        end
    end

    // Present one command until accepted, bounded
    task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int n;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_one(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                           input logic [3:0] exp_d);
        res_ready = 1'b0;
        push_one(a, b, op);
        for (int i = 0; i < 10 && !res_valid; i++) tick();
        check("one_valid", 32'(res_valid), 32'd1);
        check("one_data",  32'(res_data),  32'(exp_d));
        check("one_op",    32'(res_op),    32'(op));
`ifdef ALU_ZERO_FLAG_EN
        check("one_zero",  32'(res_zero),  32'(exp_d == 4'd0));
`endif
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        c_seq4[0] = 4'd13; c_seq4[1] = 4'd7; c_seq4[2] = 4'd11; c_seq4[3] = 4'd9;

        // Reset with a command on the input: it must not be taken
        rst = 1'b1; cmd_valid = 1'b1; cmd_a = 4'd10; cmd_b = 4'd3; cmd_op = 2'd0;
        res_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0; cmd_valid = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_op",    32'(res_op),    32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_b",     32'(alu_b),     32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd0);
`ifdef ALU_ZERO_FLAG_EN
        check("rst_res_zero",  32'(res_zero),  32'd0);
`endif
        repeat (3) tick();
        check("rst_no_accept_valid", 32'(res_valid), 32'd0);
        check("rst_no_accept_alu_a", 32'(alu_a),     32'd0);

        // Latency of a single command into an idle block
        res_ready = 1'b0;
        cmd_a = 4'd10; cmd_b = 4'd3; cmd_op = 2'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_k_alu_a",    32'(alu_a),     32'd0);
        tick();
        check("lat_k1_alu_a",   32'(alu_a),     32'd10);
        check("lat_k1_alu_b",   32'(alu_b),     32'd3);
        check("lat_k1_alu_op",  32'(alu_op),    32'd0);
        check("lat_k1_valid",   32'(res_valid), 32'd0);
        tick();
        check("lat_k2_valid",   32'(res_valid), 32'd1);
        check("lat_k2_data",    32'(res_data),  32'd13);
        check("lat_k2_op",      32'(res_op),    32'd0);
        repeat (3) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("lat_done_valid", 32'(res_valid), 32'd0);
        check("lat_alu_held",   32'(alu_a),     32'd10);

        // Four opcodes back to back, throughput one result per two cycles
        log_data.delete(); hs_cyc.delete();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_one(4'd10, 4'd3, 2'(i));
        for (int i = 0; i < 40 && log_data.size() < 4; i++) tick();
        check("seq4_count", 32'(log_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            check("seq4_data", 32'(log_data[i]), 32'(c_seq4[i]));
            if (i > 0) check("seq4_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
        end
        tick();

        // Wrap-around arithmetic
        run_one(4'd3,  4'd10, 2'b01, 4'd9);
        run_one(4'd15, 4'd1,  2'b00, 4'd0);

        // Fill the FIFO with the result held, then drain
        log_data.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_one(4'($urandom), 4'($urandom), 2'($urandom));
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = 2'd0; cmd_valid = 1'b1;
        repeat (3) tick();
        check("full_still_full", 32'(cmd_ready), 32'd0);
        check("full_held_valid", 32'(res_valid), 32'd1);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        check("full_no_comb_path", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 40 && (q_exp.size() != 0 || res_valid); i++) tick();
        check("full_drain_count", 32'(log_data.size()), 32'd5);
        check("full_drain_ready", 32'(cmd_ready),       32'd1);

        // Reset while holding a result with two commands queued
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(4'd5, 4'(i), 2'd0);
        check("hold_pre_rst_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid",     32'(res_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_alu_a",     32'(alu_a),     32'd0);
        check("mid_rst_alu_b",     32'(alu_b),     32'd0);
        check("mid_rst_alu_op",    32'(alu_op),    32'd0);
        check("mid_rst_res_data",  32'(res_data),  32'd0);
        log_data.delete();
        res_ready = 1'b1;
        repeat (8) tick();
        check("no_stale_results", 32'(log_data.size()), 32'd0);
        check("no_stale_valid",   32'(res_valid),       32'd0);

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            rst       = (i == 200 || i == 201);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_op    = 2'($urandom);
            res_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 60 && (q_exp.size() != 0 || res_valid); i++) tick();
        check("rand_drain_queue", 32'(q_exp.size()), 32'd0);
        check("rand_drain_valid", 32'(res_valid),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
